// File: rtl/score_controller.sv
// Score sequencing controller: idle/run/over state machine, v_sync frame pacing,
// two-digit saturating BCD score, and session high score for the score sprite.
module score_controller #(
  parameter int unsigned FRAMES_PER_POINT = 80
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_v_sync,
  input  logic       i_start,
  input  logic       i_collision,
  output logic [3:0] o_units,
  output logic [3:0] o_tens,
  output logic       o_tens_blank,
  output logic [3:0] o_high_units,
  output logic [3:0] o_high_tens,
  output logic [1:0] o_state,
  output logic       o_point
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [15:0] LAST_FRAME = 16'(FRAMES_PER_POINT - 1);

  state_t      state;
  logic        v_d;
  logic        vs_rise;
  logic [15:0] frame_cnt;

  assign vs_rise      = i_v_sync & ~v_d;
  assign o_state      = state;
  assign o_tens_blank = (o_tens == 4'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      v_d          <= 1'b0;
      frame_cnt    <= 16'd0;
      o_units      <= 4'd0;
      o_tens       <= 4'd0;
      o_high_units <= 4'd0;
      o_high_tens  <= 4'd0;
      o_point      <= 1'b0;
    end else begin
      v_d     <= i_v_sync;
      o_point <= 1'b0;
      case (state)
        IDLE: begin
          o_units   <= 4'd0;
          o_tens    <= 4'd0;
          frame_cnt <= 16'd0;
          if (i_start) state <= RUN;
        end
        RUN: begin
          // A collision takes priority over a coincident frame rise.
          if (i_collision) begin
            state <= OVER;
            if ({o_tens, o_units} > {o_high_tens, o_high_units}) begin
              o_high_tens  <= o_tens;
              o_high_units <= o_units;
            end
          end else if (vs_rise) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt <= 16'd0;
              o_point   <= 1'b1;
              if ({o_tens, o_units} != 8'h99) begin
                if (o_units != 4'd9) begin
                  o_units <= o_units + 4'd1;
                end else begin
                  o_units <= 4'd0;
                  o_tens  <= o_tens + 4'd1;
                end
              end
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        OVER: begin
          if (i_start) begin
            state     <= RUN;
            o_units   <= 4'd0;
            o_tens    <= 4'd0;
            frame_cnt <= 16'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller: one instance paced at 80 frames/point, one at 1 frame/point,
// both shadowed by an integer score model; table rows plus long hand-written sequences.
module tb_score_controller;

  logic clk = 1'b0;
  logic rst, v_sync, start, collision;
  always #5 clk = ~clk;

  logic [3:0] u_a, t_a, hu_a, ht_a, u_b, t_b, hu_b, ht_b;
  logic       bl_a, p_a, bl_b, p_b;
  logic [1:0] st_a, st_b;

  score_controller #(.FRAMES_PER_POINT(80)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_start(start), .i_collision(collision),
    .o_units(u_a), .o_tens(t_a), .o_tens_blank(bl_a), .o_high_units(hu_a),
    .o_high_tens(ht_a), .o_state(st_a), .o_point(p_a)
  );

  score_controller #(.FRAMES_PER_POINT(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync), .i_start(start), .i_collision(collision),
    .o_units(u_b), .o_tens(t_b), .o_tens_blank(bl_b), .o_high_units(hu_b),
    .o_high_tens(ht_b), .o_state(st_b), .o_point(p_b)
  );

  int total = 0;
  int bad   = 0;
  int pts_a = 0;

  // Reference model: score as a plain integer 0..99, state 0/1/2, rises since the last point.
  int fpp[2]     = '{80, 1};
  int m_state[2] = '{0, 0};
  int m_score[2] = '{0, 0};
  int m_high[2]  = '{0, 0};
  int m_rises[2] = '{0, 0};
  bit m_prev[2]  = '{0, 0};
  bit m_point[2] = '{0, 0};

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input int k, input bit r, input bit s, input bit c, input bit v);
    bit rise;
    rise = v && !m_prev[k];
    if (r) begin
      m_state[k] = 0; m_score[k] = 0; m_high[k] = 0; m_rises[k] = 0;
      m_prev[k] = 0; m_point[k] = 0;
    end else begin
      m_prev[k]  = v;
      m_point[k] = 0;
      case (m_state[k])
        0: begin
          m_score[k] = 0;
          m_rises[k] = 0;
          if (s) m_state[k] = 1;
        end
        1: begin
          if (c) begin
            m_state[k] = 2;
            if (m_score[k] > m_high[k]) m_high[k] = m_score[k];
          end else if (rise) begin
            m_rises[k]++;
            if (m_rises[k] == fpp[k]) begin
              m_rises[k] = 0;
              m_point[k] = 1;
              if (m_score[k] < 99) m_score[k]++;
            end
          end
        end
        default: begin
          if (s) begin
            m_state[k] = 1; m_score[k] = 0; m_rises[k] = 0;
          end
        end
      endcase
    end
  endtask

  task automatic check_inst(input int k, input logic [3:0] u, input logic [3:0] t,
                            input logic bl, input logic [3:0] hu, input logic [3:0] ht,
                            input logic [1:0] st, input logic p);
    string n;
    n = (k == 0) ? "a" : "b";
    check({"model_state_", n}, int'(st), m_state[k]);
    check({"model_units_", n}, int'(u), m_score[k] % 10);
    check({"model_tens_", n}, int'(t), m_score[k] / 10);
    check({"model_blank_", n}, int'(bl), (m_score[k] / 10 == 0) ? 1 : 0);
    check({"model_high_units_", n}, int'(hu), m_high[k] % 10);
    check({"model_high_tens_", n}, int'(ht), m_high[k] / 10);
    check({"model_point_", n}, int'(p), int'(m_point[k]));
  endtask

  task automatic step(input bit r, input bit s, input bit c, input bit v);
    rst = r; start = s; collision = c; v_sync = v;
    @(posedge clk);
    model_update(0, r, s, c, v);
    model_update(1, r, s, c, v);
    #1;
    check_inst(0, u_a, t_a, bl_a, hu_a, ht_a, st_a, p_a);
    check_inst(1, u_b, t_b, bl_b, hu_b, ht_b, st_b, p_b);
    if (p_a) pts_a++;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic check_a(input string name, input int exp_state, input int exp_score,
                         input int exp_high);
    check({name, "_state"}, int'(st_a), exp_state);
    check({name, "_score"}, int'(t_a) * 10 + int'(u_a), exp_score);
    check({name, "_blank"}, int'(bl_a), (exp_score < 10) ? 1 : 0);
    check({name, "_high"}, int'(ht_a) * 10 + int'(hu_a), exp_high);
  endtask

  typedef struct {
    bit r, s, c, v;
    int st, score, high;
    bit p;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int p0;
    rst = 1'b1; start = 1'b0; collision = 1'b0; v_sync = 1'b0;

    // Hand-computed vectors for the one-frame-per-point instance.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 1, 1, 0, 1};
    tbl[5]  = '{0, 0, 0, 1, 1, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 1, 2, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 1, 2, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 2, 2, 2, 0};
    tbl[10] = '{0, 0, 0, 0, 2, 2, 2, 0};
    tbl[11] = '{0, 0, 0, 1, 2, 2, 2, 0};
    tbl[12] = '{0, 1, 1, 0, 1, 0, 2, 0};
    tbl[13] = '{0, 0, 0, 1, 1, 1, 2, 1};
    tbl[14] = '{0, 0, 0, 0, 1, 1, 2, 0};
    tbl[15] = '{1, 0, 0, 1, 0, 0, 0, 0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].v);
      check($sformatf("tbl%0d_state", i), int'(st_b), tbl[i].st);
      check($sformatf("tbl%0d_score", i), int'(t_b) * 10 + int'(u_b), tbl[i].score);
      check($sformatf("tbl%0d_high", i), int'(ht_b) * 10 + int'(hu_b), tbl[i].high);
      check($sformatf("tbl%0d_point", i), int'(p_b), int'(tbl[i].p));
    end

    // Reset then run at 80 frames per point.
    step(1, 0, 0, 0);
    check_a("reset", 0, 0, 0);
    check("reset_point", int'(p_a), 0);
    step(0, 1, 0, 0);
    check_a("start", 1, 0, 0);
    pts_a = 0;
    pulse(79);
    check_a("pulse79", 1, 0, 0);
    pulse(641);
    check_a("pulse720", 1, 9, 0);
    pulse(80);
    check_a("pulse800", 1, 10, 0);
    check("points800", pts_a, 10);

    // Collision on the 80th rise of a point: no increment, high score captured.
    pulse(2160);
    check_a("score37", 1, 37, 0);
    pulse(79);
    p0 = pts_a;
    step(0, 0, 1, 1);
    check_a("collide37", 2, 37, 37);
    check("collide37_nopoint", pts_a - p0, 0);
    step(0, 0, 0, 0);

    // Lower score does not replace the high score.
    step(0, 1, 0, 0);
    check_a("restart", 1, 0, 37);
    pulse(960);
    step(0, 0, 1, 0);
    check_a("collide12", 2, 12, 37);

    // Start wins over collision in OVER; frame count restarts from zero.
    step(0, 1, 1, 0);
    check_a("start_and_coll", 1, 0, 37);
    pulse(79);
    check_a("fresh_frames79", 1, 0, 37);
    pulse(1);
    check_a("fresh_frames80", 1, 1, 37);

    // A long high level of v_sync counts as a single frame.
    repeat (500) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    pulse(78);
    check_a("held_high", 1, 1, 37);
    pulse(1);
    check_a("held_high_next", 1, 2, 37);

    // Build high 60 and score 45, then reset coincident with a rise.
    pulse(4640);
    step(0, 0, 1, 0);
    check_a("high60", 2, 60, 60);
    step(0, 1, 0, 0);
    pulse(3600);
    check_a("score45", 1, 45, 60);
    pulse(79);
    step(1, 0, 0, 1);
    check_a("mid_run_reset", 0, 0, 0);
    check("mid_run_reset_point", int'(p_a), 0);

    // Collision alone in IDLE is ignored.
    step(0, 0, 1, 0);
    check_a("idle_collision", 0, 0, 0);

    // Saturation at 99 still pulses o_point.
    step(0, 1, 0, 0);
    pulse(7920);
    check_a("score99", 1, 99, 0);
    p0 = pts_a;
    pulse(80);
    check_a("saturate", 1, 99, 0);
    check("saturate_points", pts_a - p0, 1);

    // Random traffic against the model.
    repeat (3000) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
